// File: rtl/td4_pkg.sv
// Shared constants and state encoding for the TD4 program memory.
package td4_pkg;

    localparam int unsigned WORDS = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pin_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, followed by a rising-edge
// detector producing a one-cycle strobe.
module pin_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/td4_prog_mem.sv
// Writable 16x8 TD4 program memory with bit-serial loader; holds the CPU in
// reset while a program is being shifted in.
module td4_prog_mem
    import td4_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addres,
    output logic [DW-1:0] data,
    input  logic          prog_en,
    input  logic          prog_sclk,
    input  logic          prog_sdi,
    output logic          cpu_rst,
    output logic          busy,
    output logic [AW-1:0] wptr
);

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_mem [WORDS];
    logic [AW-1:0] r_wptr;
    logic [2:0]    r_cnt;
    logic [DW-2:0] r_sr;
    logic          r_en_s1;
    logic          r_en_s2;
    logic          r_sdi_d1;
    logic          r_sdi_d2;
    logic          r_rst_done;
    logic          w_bit_stb;
    logic          w_last_bit;
    logic          w_cpu_rst;
    logic          w_busy;
    logic          w_rd_en;

    pin_sync_edge u_sclk_sync (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_pin  (prog_sclk),
        .o_rise (w_bit_stb)
    );

    // sdi delayed by the same two stages as sclk so the strobe samples the matching bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_en_s1    <= 1'b0;
            r_en_s2    <= 1'b0;
            r_sdi_d1   <= 1'b0;
            r_sdi_d2   <= 1'b0;
            r_rst_done <= 1'b0;
        end else begin
            r_en_s1    <= prog_en;
            r_en_s2    <= r_en_s1;
            r_sdi_d1   <= prog_sdi;
            r_sdi_d2   <= r_sdi_d1;
            r_rst_done <= 1'b1;
        end
    end

    assign w_last_bit = w_bit_stb && (r_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (r_en_s2) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (!r_en_s2)
                    w_next = ST_RUN;
                else if (w_last_bit && (r_wptr == 4'd15))
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                if (!r_en_s2) w_next = ST_RUN;
            end
            default: w_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_cpu_rst = 1'b0;
        w_busy    = 1'b0;
        w_rd_en   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_cpu_rst = r_rst_done;
                w_rd_en   = 1'b1;
            end
            ST_LOAD: begin
                w_busy = 1'b1;
            end
            ST_DONE: begin
                w_rd_en = 1'b1;
            end
            default: begin
                w_cpu_rst = 1'b0;
            end
        endcase
    end

    // An abort (prog_en low) takes priority over a coincident bit strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                r_mem[AW'(i)] <= '0;
            end
            r_wptr <= '0;
            r_cnt  <= '0;
            r_sr   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_en_s2) begin
                        r_wptr <= '0;
                        r_cnt  <= '0;
                        r_sr   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (r_en_s2 && w_bit_stb) begin
                        r_sr  <= {r_sr[DW-3:0], r_sdi_d2};
                        r_cnt <= r_cnt + 3'd1;
                        if (w_last_bit) begin
                            r_mem[r_wptr] <= {r_sr, r_sdi_d2};
                            r_wptr        <= r_wptr + 4'd1;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign data    = w_rd_en ? r_mem[addres] : '0;
    assign cpu_rst = w_cpu_rst;
    assign busy    = w_busy;
    assign wptr    = r_wptr;

endmodule

// File: tb/tb_td4_prog_mem.sv
// Self-checking bench for td4_prog_mem: reference memory model plus a
// queue scoreboard for the read path and status outputs.
module tb_td4_prog_mem;

    logic       clk;
    logic       rst;
    logic [3:0] addres;
    logic [7:0] data;
    logic       prog_en;
    logic       prog_sclk;
    logic       prog_sdi;
    logic       cpu_rst;
    logic       busy;
    logic [3:0] wptr;

    logic [7:0] m_mem [16];
    logic [7:0] m_q [$];
    int n_cmp;
    int n_err;

    td4_prog_mem dut (
        .clk       (clk),
        .rst       (rst),
        .addres    (addres),
        .data      (data),
        .prog_en   (prog_en),
        .prog_sclk (prog_sclk),
        .prog_sdi  (prog_sdi),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .wptr      (wptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, need 0x%02h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            prog_sdi = b[i];
            cycles(2);
            prog_sclk = 1'b1;
            cycles(4);
            prog_sclk = 1'b0;
            cycles(2);
        end
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            addres = 4'(a);
            m_q.push_back(m_mem[a]);
            #1;
            check($sformatf("%s[%0d]", tag, a), data, m_q.pop_front());
        end
    endtask

    task automatic status(input string tag, input logic c, input logic b, input logic [3:0] w);
        m_q.push_back({7'd0, c});
        m_q.push_back({7'd0, b});
        m_q.push_back({4'd0, w});
        check({tag, ".cpu_rst"}, {7'd0, cpu_rst}, m_q.pop_front());
        check({tag, ".busy"},    {7'd0, busy},    m_q.pop_front());
        check({tag, ".wptr"},    {4'd0, wptr},    m_q.pop_front());
    endtask

    initial begin
        logic [7:0] b;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        prog_en = 1'b0;
        prog_sclk = 1'b0;
        prog_sdi = 1'b0;
        addres = 4'd0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

        // reset
        cycles(2);
        status("in_reset", 1'b0, 1'b0, 4'd0);
        rst = 1'b1;
        #1;
        check("release_pre_edge.cpu_rst", {7'd0, cpu_rst}, 8'h00);
        cycles(1);
        status("after_reset", 1'b1, 1'b0, 4'd0);
        read_all("reset_mem");

        // full load with entry latency check
        @(negedge clk);
        prog_en = 1'b1;
        cycles(2);
        check("en_rise_2edges.cpu_rst", {7'd0, cpu_rst}, 8'h01);
        cycles(1);
        status("load_entry", 1'b0, 1'b1, 4'd0);
        addres = 4'd5;
        #1;
        check("load_data_forced", data, 8'h00);
        for (int k = 0; k < 16; k++) begin
            b = (k == 0) ? 8'hB1 : 8'(k);
            m_mem[k] = b;
            check($sformatf("busy_before_byte%0d", k), {7'd0, busy}, 8'h01);
            send_bits(b, 8);
        end
        status("done", 1'b0, 1'b0, 4'd0);

        // extra bits in DONE are ignored
        send_bits(8'h5A, 8);
        status("done_extra", 1'b0, 1'b0, 4'd0);

        @(negedge clk);
        prog_en = 1'b0;
        cycles(2);
        check("en_fall_2edges.cpu_rst", {7'd0, cpu_rst}, 8'h00);
        cycles(1);
        status("run_after_load", 1'b1, 1'b0, 4'd0);
        read_all("loaded_mem");

        // abort after 3 bytes + 5 bits
        @(negedge clk);
        prog_en = 1'b1;
        cycles(3);
        addres = 4'd0;
        #1;
        check("abort_load_data_forced", data, 8'h00);
        for (int k = 0; k < 3; k++) begin
            b = 8'hA0 + 8'(k);
            m_mem[k] = b;
            send_bits(b, 8);
        end
        send_bits(8'hC3, 5);
        status("abort_pre", 1'b0, 1'b1, 4'd3);
        @(negedge clk);
        prog_en = 1'b0;
        cycles(2);
        check("abort_2edges.cpu_rst", {7'd0, cpu_rst}, 8'h00);
        cycles(1);
        status("abort_run", 1'b1, 1'b0, 4'd3);
        read_all("abort_mem");

        // reset mid-load after two bytes
        @(negedge clk);
        prog_en = 1'b1;
        cycles(3);
        send_bits(8'h77, 8);
        send_bits(8'h88, 8);
        status("midload_pre", 1'b0, 1'b1, 4'd2);
        rst = 1'b0;
        prog_en = 1'b0;
        cycles(2);
        status("midload_rst", 1'b0, 1'b0, 4'd0);
        rst = 1'b1;
        cycles(1);
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        status("midload_release", 1'b1, 1'b0, 4'd0);
        read_all("midload_mem");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
